// File: rtl/fmul_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined fmul between NUM_REQ requesters, with
// credit-guarded tagged response buffering and a drain/flush handshake. Optional: FMUL_ARB_STATS_EN.
module fmul_issue_arbiter #(
  parameter int unsigned EXP_WIDTH  = 5,
  parameter int unsigned FRAC_WIDTH = 3,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RESP_DEPTH = 8,
  parameter int unsigned ID_W       = 2,
  localparam int unsigned W         = EXP_WIDTH + FRAC_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_rm,
  output logic                 fm_in_valid,
  input  logic                 fm_in_ready,
  output logic [W-1:0]         fm_a,
  output logic [W-1:0]         fm_b,
  output logic [2:0]           fm_rm,
  input  logic                 fm_out_valid,
  output logic                 fm_out_ready,
  input  logic [W-1:0]         fm_result,
  input  logic [4:0]           fm_fflags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_result,
  output logic [4:0]           rsp_fflags,
  input  logic                 flush_i,
  output logic                 flush_done_o,
`ifdef FMUL_ARB_STATS_EN
  output logic                 busy_o,
  output logic [31:0]          stat_issue_o,
  output logic [31:0]          stat_stall_o,
  output logic [31:0]          stat_full_o
`else
  output logic                 busy_o
`endif
);

  localparam int unsigned AW = $clog2(RESP_DEPTH);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned RW = ID_W + W + 5;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e          state_q;
  logic [ID_W-1:0] ptr_q, ptr_nxt, winner;
  logic [ID_W:0]   slot;
  logic            found;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, flush_done_q;
  logic            can_issue, issue, tag_pop, rsp_pop;

  logic [ID_W-1:0] tag_mem [RESP_DEPTH];
  logic [AW-1:0]   tag_wp_q, tag_rp_q;
  logic [CW-1:0]   tag_cnt_q;
  logic [RW-1:0]   rsp_mem [RESP_DEPTH];
  logic [AW-1:0]   rsp_wp_q, rsp_rp_q;
  logic [CW-1:0]   rsp_cnt_q;
  logic [RW-1:0]   rsp_head;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    slot   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      slot = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(NUM_REQ)) slot = slot - (ID_W+1)'(NUM_REQ);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && slot == (ID_W+1)'(i)) begin
          found  = 1'b1;
          winner = ID_W'(i);
        end
      end
    end
  end

  assign can_issue   = (state_q == StRun) && (cnt_q < CW'(RESP_DEPTH));
  assign fm_in_valid = can_issue && found;
  assign issue       = fm_in_valid && fm_in_ready;
  assign ptr_nxt     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    fm_a      = '0;
    fm_b      = '0;
    fm_rm     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (found && winner == ID_W'(i)) begin
        req_ready[i] = can_issue && fm_in_ready;
        fm_a         = req_a[i*W +: W];
        fm_b         = req_b[i*W +: W];
        fm_rm        = req_rm[i*3 +: 3];
      end
    end
  end

  // Credits reserve buffer space for every issued op, so results are always accepted.
  assign fm_out_ready = 1'b1;
  assign tag_pop      = fm_out_valid && (tag_cnt_q != '0);
  assign rsp_valid    = (rsp_cnt_q != '0);
  assign rsp_pop      = rsp_valid && rsp_ready;
  assign rsp_head     = rsp_mem[rsp_rp_q];
  assign {rsp_id, rsp_result, rsp_fflags} = rsp_valid ? rsp_head : '0;
  assign cnt_d        = cnt_q + CW'(issue) - CW'(rsp_pop);
  assign busy_o       = busy_q;
  assign flush_done_o = flush_done_q;

  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wp_q] <= winner;
    if (tag_pop) rsp_mem[rsp_wp_q] <= {tag_mem[tag_rp_q], fm_result, fm_fflags};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      ptr_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      tag_wp_q     <= '0;
      tag_rp_q     <= '0;
      tag_cnt_q    <= '0;
      rsp_wp_q     <= '0;
      rsp_rp_q     <= '0;
      rsp_cnt_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= (cnt_d != '0);
      if (issue) ptr_q <= ptr_nxt;
      if (issue) tag_wp_q <= tag_wp_q + 1'b1;
      if (tag_pop) begin
        tag_rp_q <= tag_rp_q + 1'b1;
        rsp_wp_q <= rsp_wp_q + 1'b1;
      end
      if (rsp_pop) rsp_rp_q <= rsp_rp_q + 1'b1;
      tag_cnt_q <= tag_cnt_q + CW'(issue) - CW'(tag_pop);
      rsp_cnt_q <= rsp_cnt_q + CW'(tag_pop) - CW'(rsp_pop);
      unique case (state_q)
        StRun:   if (flush_i) state_q <= StDrain;
        StDrain: if (cnt_q == '0) begin
          state_q      <= StDone;
          flush_done_q <= 1'b1;
        end
        StDone:  if (!flush_i) begin
          state_q      <= StRun;
          flush_done_q <= 1'b0;
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef FMUL_ARB_STATS_EN
  logic [31:0] stat_issue_q, stat_stall_q, stat_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
      stat_full_q  <= '0;
    end else begin
      if (issue && stat_issue_q != '1) stat_issue_q <= stat_issue_q + 1'b1;
      if (found && !issue && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 1'b1;
      if (cnt_q == CW'(RESP_DEPTH) && stat_full_q != '1) stat_full_q <= stat_full_q + 1'b1;
    end
  end

  assign stat_issue_o = stat_issue_q;
  assign stat_stall_o = stat_stall_q;
  assign stat_full_o  = stat_full_q;
`endif

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Bench for fmul_issue_arbiter: a 3-stage fmul stand-in, holding requesters and a
// queue-based reference model; directed scenarios followed by a randomized run.
module tb_fmul_issue_arbiter;
  localparam int NR = 4;
  localparam int W = 9;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*W-1:0] req_a, req_b;
  logic [NR*3-1:0] req_rm;
  logic            fm_in_valid, fm_in_ready;
  logic [W-1:0]    fm_a, fm_b;
  logic [2:0]      fm_rm;
  logic            fm_out_valid, fm_out_ready;
  logic [W-1:0]    fm_result;
  logic [4:0]      fm_fflags;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_result;
  logic [4:0]      rsp_fflags;
  logic            flush_i, flush_done_o, busy_o;
`ifdef FMUL_ARB_STATS_EN
  logic [31:0]     stat_issue_o, stat_stall_o, stat_full_o;
`endif

  fmul_issue_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .req_b(req_b), .req_rm(req_rm), .fm_in_valid(fm_in_valid), .fm_in_ready(fm_in_ready),
    .fm_a(fm_a), .fm_b(fm_b), .fm_rm(fm_rm), .fm_out_valid(fm_out_valid),
    .fm_out_ready(fm_out_ready), .fm_result(fm_result), .fm_fflags(fm_fflags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_fflags(rsp_fflags), .flush_i(flush_i), .flush_done_o(flush_done_o),
`ifdef FMUL_ARB_STATS_EN
    .busy_o(busy_o), .stat_issue_o(stat_issue_o), .stat_stall_o(stat_stall_o),
    .stat_full_o(stat_full_o)
`else
    .busy_o(busy_o)
`endif
  );

  typedef struct packed {logic [1:0] id; logic [8:0] res; logic [4:0] fl;} rsp_t;

  // requesters, multiplier stand-in pipe, reference model, logs
  logic       pend [NR];
  logic [8:0] ra [NR], rb [NR];
  logic [2:0] rrm [NR];
  logic       pv [3];
  logic [8:0] pr [3];
  logic [4:0] pf [3];
  int         mcnt, mptr, mtags, mvis, mstate;
  rsp_t       expq [$];
  int         grant_log [$];
  rsp_t       pop_log [$];
  int         nchk, nerr, cyc, last_pop_cyc, done_cyc, narmed;

  // Stand-in multiply (truncating, normal range only); rm is echoed into flags[4:2].
  function automatic logic [13:0] fmul_ref(input logic [8:0] a, input logic [8:0] b,
                                           input logic [2:0] rm);
    int ma, mb, pp, e;
    logic [2:0] fr;
    logic inx;
    ma = 8 + int'(a[2:0]);
    mb = 8 + int'(b[2:0]);
    pp = ma * mb;
    e  = int'(a[7:3]) + int'(b[7:3]) - 15;
    if (pp >= 128) begin
      fr = pp[6:4]; e = e + 1; inx = (pp % 16) != 0;
    end else begin
      fr = pp[5:3]; inx = (pp % 8) != 0;
    end
    return {rm, 1'b0, inx, a[8] ^ b[8], e[4:0], fr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int i, input logic [8:0] a, input logic [8:0] b, input logic [2:0] rm);
    pend[i] = 1'b1; ra[i] = a; rb[i] = b; rrm[i] = rm;
  endtask

  task automatic arm_rand(input int i);
    logic [8:0] a, b;
    a = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 3'($urandom_range(0, 7))};
    b = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 3'($urandom_range(0, 7))};
    arm(i, a, b, 3'($urandom_range(0, 7)));
  endtask

  task automatic step();
    int w, idx, nst;
    logic exp_v, m_issue, m_pop, iss_obs;
    logic [NR-1:0] exp_rdy;
    logic [13:0] fr;
    rsp_t e;
    fm_out_valid = pv[2]; fm_result = pr[2]; fm_fflags = pf[2];
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pend[i]; req_a[i*W +: W] = ra[i]; req_b[i*W +: W] = rb[i];
      req_rm[i*3 +: 3] = rrm[i];
    end
    #2;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (mptr + k) % NR;
      if (w < 0 && pend[idx]) w = idx;
    end
    exp_v = (mstate == 0) && (mcnt < D) && (w >= 0);
    exp_rdy = '0;
    if (exp_v && fm_in_ready) exp_rdy[w] = 1'b1;
    chk("fm_in_valid", fm_in_valid, exp_v);
    chk("req_ready", req_ready, exp_rdy);
    chk("fm_a", fm_a, (w >= 0) ? ra[w] : 9'd0);
    chk("fm_b", fm_b, (w >= 0) ? rb[w] : 9'd0);
    chk("fm_rm", fm_rm, (w >= 0) ? rrm[w] : 3'd0);
    chk("rsp_valid", rsp_valid, mvis > 0);
    if (mvis > 0) begin
      chk("rsp_id", rsp_id, expq[0].id);
      chk("rsp_result", rsp_result, expq[0].res);
      chk("rsp_fflags", rsp_fflags, expq[0].fl);
    end
    chk("busy_o", busy_o, mcnt != 0);
    chk("flush_done_o", flush_done_o, mstate == 2);
    chk("fm_out_ready", fm_out_ready, 1);
    // environment reacts to what the DUT actually did
    iss_obs = fm_in_valid && fm_in_ready;
    for (int i = 0; i < NR; i++)
      if (req_ready[i] && pend[i]) begin pend[i] = 1'b0; grant_log.push_back(i); end
    if (rsp_valid && rsp_ready) begin
      pop_log.push_back({rsp_id, rsp_result, rsp_fflags});
      last_pop_cyc = cyc;
    end
    fr = fmul_ref(fm_a, fm_b, fm_rm);
    pv[2] = pv[1]; pr[2] = pr[1]; pf[2] = pf[1];
    pv[1] = pv[0]; pr[1] = pr[0]; pf[1] = pf[0];
    pv[0] = iss_obs; pr[0] = fr[8:0]; pf[0] = fr[13:9];
    // reference model advance
    if (rst) begin
      mcnt = 0; mptr = 0; mtags = 0; mvis = 0; mstate = 0; expq.delete();
    end else begin
      m_issue = exp_v && fm_in_ready;
      m_pop = (mvis > 0) && rsp_ready;
      nst = mstate;
      if (mstate == 0 && flush_i) nst = 1;
      if (mstate == 1 && mcnt == 0) nst = 2;
      if (mstate == 2 && !flush_i) nst = 0;
      mstate = nst;
      if (m_pop) begin void'(expq.pop_front()); mvis--; end
      if (fm_out_valid && mtags > 0) begin mtags--; mvis++; end
      if (m_issue) begin
        fr = fmul_ref(ra[w], rb[w], rrm[w]);
        e.id = 2'(w); e.res = fr[8:0]; e.fl = fr[13:9];
        expq.push_back(e);
        mtags++;
        mptr = (w + 1) % NR;
      end
      mcnt = mcnt + int'(m_issue) - int'(m_pop);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_fm_in_valid"}, fm_in_valid, 0);
    chk({tag, "_fm_a"}, fm_a, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_fflags"}, rsp_fflags, 0);
    chk({tag, "_flush_done"}, flush_done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic pulse_reset(input string tag);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    zero_chk(tag);
    grant_log.delete();
    pop_log.delete();
  endtask

  initial begin
    nchk = 0; nerr = 0; cyc = 0; last_pop_cyc = -1;
    rst = 1'b1; flush_i = 1'b0; rsp_ready = 1'b1; fm_in_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_rm = '0;
    fm_out_valid = 1'b0; fm_result = '0; fm_fflags = '0;
    for (int i = 0; i < NR; i++) begin pend[i] = 0; ra[i] = 0; rb[i] = 0; rrm[i] = 0; end
    for (int s = 0; s < 3; s++) begin pv[s] = 0; pr[s] = 0; pf[s] = 0; end
    mcnt = 0; mptr = 0; mtags = 0; mvis = 0; mstate = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    zero_chk("reset");

    // single op: 1.0 * 2.0
    arm(0, 9'h078, 9'h080, 3'd0);
    repeat (8) step();
    chk("single_grants", grant_log.size(), 1);
    chk("single_pops", pop_log.size(), 1);
    if (pop_log.size() == 1) chk("single_rsp", pop_log[0], {2'd0, 9'h080, 5'd0});
    chk("single_busy_after", busy_o, 0);

    // round robin with 1.5 * 1.5 everywhere
    pulse_reset("rr_rst");
    narmed = 0;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NR; i++)
        if (!pend[i] && narmed < 8) begin arm(i, 9'h07C, 9'h07C, 3'd0); narmed++; end
      step();
    end
    chk("rr_grants", grant_log.size(), 8);
    chk("rr_pops", pop_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < grant_log.size()) chk("rr_order", grant_log[k], k % NR);
      if (k < pop_log.size()) chk("rr_rsp", pop_log[k], {2'(k % NR), 9'h081, 5'd0});
    end

    // credit-full stall
    grant_log.delete(); pop_log.delete();
    rsp_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NR; i++) if (!pend[i]) arm_rand(i);
      step();
    end
    chk("stall_issues", grant_log.size(), D);
    chk("stall_in_valid", fm_in_valid, 0);
    chk("stall_ready", req_ready, 0);
    rsp_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NR; i++) if (!pend[i]) arm_rand(i);
      step();
    end
    chk("stall_drained", pop_log.size() >= D, 1);
    chk("stall_resumed", grant_log.size() > D, 1);
    repeat (30) step();

    // flush with three ops in flight
    pulse_reset("flush_rst");
    rsp_ready = 1'b0;
    arm_rand(0); arm_rand(1); arm_rand(2);
    repeat (3) step();
    chk("flush_pre_grants", grant_log.size(), 3);
    flush_i = 1'b1;
    step();
    arm_rand(3); arm_rand(0);
    repeat (4) step();
    chk("drain_no_grant", grant_log.size(), 3);
    rsp_ready = 1'b1;
    done_cyc = -1;
    for (int n = 0; n < 20 && done_cyc < 0; n++) begin
      step();
      if (flush_done_o) done_cyc = cyc;
    end
    chk("flush_done_seen", done_cyc >= 0, 1);
    chk("flush_pops", pop_log.size(), 3);
    // pop edge, then one more edge to reach DONE
    chk("flush_done_lag", done_cyc - last_pop_cyc, 2);
    chk("flush_hold_grants", grant_log.size(), 3);
    flush_i = 1'b0;
    for (int n = 0; n < 6 && grant_log.size() == 3; n++) step();
    chk("post_flush_grant_seen", grant_log.size() > 3, 1);
    if (grant_log.size() > 3) chk("post_flush_grant", grant_log[3], 3);
    repeat (20) step();

    // reset with five ops outstanding
    grant_log.delete(); pop_log.delete();
    rsp_ready = 1'b0;
    for (int n = 0; n < 10 && grant_log.size() < 5; n++) begin
      for (int i = 0; i < NR; i++) if (!pend[i]) arm_rand(i);
      step();
    end
    chk("mid_outstanding", grant_log.size(), 5);
    pulse_reset("mid_rst");
    rsp_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("late_rsp_valid", rsp_valid, 0);
    end
    chk("late_pops", pop_log.size(), 0);
    chk("late_busy", busy_o, 0);

    // randomized traffic with occasional flushes
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) if (!pend[i] && $urandom_range(0, 9) < 4) arm_rand(i);
      fm_in_ready = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 9) < 6;
      if ($urandom_range(0, 39) == 0) flush_i = ~flush_i;
      step();
    end
    flush_i = 1'b0; rsp_ready = 1'b1; fm_in_ready = 1'b1;
    repeat (60) step();
    chk("final_idle", busy_o, 0);
    chk("final_model_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
